irq_controller_vec: RTL and testbench

Parametrised, multi-source successor to the core's single-line interrupt controller. It accepts N_IRQ request lines, each configurable as edge- or level-type, and keeps a pending register per line. It arbitrates by fixed priority (index 0 highest) against per-source and global enables, and tracks trap nesting (IRQ, exception, exception-inside-IRQ) so the core gets a correct irq_ret_o. It sits between the external request lines and the core's trap/CSR logic, and drives irq_o, mcause and the mip view.

---
 rtl/irq_controller_vec.sv | 133 +++++++++++++
 tb/tb_irq_controller_vec.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/irq_controller_vec.sv
// Multi-source interrupt controller: per-line edge/level pending capture,
// fixed-priority arbitration (index 0 highest) and trap-nesting tracking so
// that irq_ret_o fires only for an mret that leaves an IRQ handler.

// One request line: pending capture and the previous-sample register.
module irq_src_cell #(
    parameter bit EDGE = 1'b1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic req_i,
    input  logic ack_i,
    output logic pending_o
);
    logic prev_q, prev_d;
    logic pend_q, pend_d;

    // Edge: set on a rising edge, clear on ack; the new edge wins over the ack.
    // Level: the pending bit simply follows the registered request.
    always_comb begin
        prev_d = req_i;
        if (EDGE) pend_d = (req_i & ~prev_q) | (pend_q & ~ack_i);
        else      pend_d = req_i;
    end

    // Request history and pending state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prev_q <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
            pend_q <= pend_d;
        end
    end

    assign pending_o = pend_q;
endmodule

module irq_controller_vec #(
    parameter int          N_IRQ      = 16,
    parameter logic [15:0] EDGE_MASK  = 16'hFFFF,
    parameter int          CAUSE_BASE = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             stall_i,
    input  logic             exception_i,
    input  logic             mret_i,
    input  logic             mie_global_i,
    input  logic [N_IRQ-1:0] mie_i,
    input  logic [N_IRQ-1:0] irq_req_i,
    output logic             irq_o,
    output logic [31:0]      irq_cause_o,
    output logic [N_IRQ-1:0] irq_ack_o,
    output logic             irq_ret_o,
    output logic [N_IRQ-1:0] pending_o
);
    // Trap nesting: EXC is an exception outside any handler, IRQ_EXC an
    // exception raised inside an IRQ handler.
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_IRQ     = 2'd1;
    localparam logic [1:0] S_IRQ_EXC = 2'd2;
    localparam logic [1:0] S_EXC     = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [31:0]      cause_q, cause_d;
    logic [N_IRQ-1:0] pend;
    logic [N_IRQ-1:0] elig;
    logic [4:0]       win_idx;
    logic [31:0]      win_cause;

    genvar g;
    generate
        for (g = 0; g < N_IRQ; g++) begin : g_src
            irq_src_cell #(.EDGE(EDGE_MASK[g])) u_src (
                .clk_i     (clk_i),
                .rst_ni    (rst_ni),
                .req_i     (irq_req_i[g]),
                .ack_i     (irq_ack_o[g]),
                .pending_o (pend[g])
            );
        end
    endgenerate

    assign pending_o = pend;
    assign elig      = pend & mie_i & {N_IRQ{mie_global_i}};

    // Lowest eligible index wins: scan downward so the last hit is the lowest.
    always_comb begin
        win_idx = 5'd0;
        for (int i = N_IRQ - 1; i >= 0; i--)
            if (elig[i]) win_idx = 5'(i);
    end

    assign win_cause = {1'b1, 26'b0, 5'(CAUSE_BASE + int'(win_idx))};

    // Take decision and one-hot ack; exceptions pre-empt interrupts.
    always_comb begin
        irq_o     = (state_q == S_IDLE) & (|elig) & ~stall_i & ~exception_i;
        irq_ack_o = '0;
        for (int i = 0; i < N_IRQ; i++)
            irq_ack_o[i] = irq_o & (win_idx == 5'(i));
        irq_ret_o   = (state_q == S_IRQ) & mret_i & ~exception_i;
        irq_cause_o = irq_o ? win_cause : cause_q;
    end

    // Trap-nesting state and cause latch; exception beats a same-cycle mret.
    always_comb begin
        state_d = state_q;
        cause_d = irq_o ? win_cause : cause_q;
        case (state_q)
            S_IDLE:    if (exception_i) state_d = S_EXC;
                       else if (irq_o)  state_d = S_IRQ;
            S_IRQ:     if (exception_i) state_d = S_IRQ_EXC;
                       else if (mret_i) state_d = S_IDLE;
            S_IRQ_EXC: if (!exception_i && mret_i) state_d = S_IRQ;
            S_EXC:     if (!exception_i && mret_i) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Controller state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            cause_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
        end
    end
endmodule

// File: tb/tb_irq_controller_vec.sv
// Directed bench for irq_controller_vec: 4 sources, 0/1 edge, 2/3 level.
module tb_irq_controller_vec;
    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       stall_i, exception_i, mret_i, mie_global_i;
    logic [3:0] mie_i, irq_req_i;
    logic       irq_o, irq_ret_o;
    logic [31:0] irq_cause_o;
    logic [3:0] irq_ack_o, pending_o;

    int checks = 0;
    int errors = 0;

    irq_controller_vec #(.N_IRQ(4), .EDGE_MASK(16'h0003), .CAUSE_BASE(16)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .stall_i      (stall_i),
        .exception_i  (exception_i),
        .mret_i       (mret_i),
        .mie_global_i (mie_global_i),
        .mie_i        (mie_i),
        .irq_req_i    (irq_req_i),
        .irq_o        (irq_o),
        .irq_cause_o  (irq_cause_o),
        .irq_ack_o    (irq_ack_o),
        .irq_ret_o    (irq_ret_o),
        .pending_o    (pending_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    // Inputs change 2 time units after the rising edge; checks follow 1 later.
    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst_ni = 1'b0; stall_i = 0; exception_i = 0; mret_i = 0;
        mie_global_i = 1; mie_i = 4'hF; irq_req_i = 4'h0;
        #3;
        chk("rst_irq", 32'(irq_o), 32'd0);
        chk("rst_ack", 32'(irq_ack_o), 32'd0);
        chk("rst_ret", 32'(irq_ret_o), 32'd0);
        chk("rst_cause", irq_cause_o, 32'd0);
        chk("rst_pend", 32'(pending_o), 32'd0);
        repeat (2) tick();
        rst_ni = 1'b1;
        settle();
        chk("post_rst_irq", 32'(irq_o), 32'd0);
        chk("post_rst_cause", irq_cause_o, 32'd0);

        // single edge pulse on source 1
        irq_req_i = 4'b0010; tick(); irq_req_i = 4'b0000; settle();
        chk("t1_pend", 32'(pending_o), 32'h2);
        chk("t1_irq", 32'(irq_o), 32'd1);
        chk("t1_ack", 32'(irq_ack_o), 32'h2);
        chk("t1_cause", irq_cause_o, 32'h8000_0011);
        tick(); settle();
        chk("t1_pend_clr", 32'(pending_o), 32'd0);
        chk("t1_irq_busy", 32'(irq_o), 32'd0);
        chk("t1_cause_hold", irq_cause_o, 32'h8000_0011);
        mret_i = 1; settle();
        chk("t1_ret", 32'(irq_ret_o), 32'd1);
        tick(); mret_i = 0;

        // level 3 and edge 1 together: 1 first, then 3
        irq_req_i = 4'b1010; tick(); irq_req_i = 4'b1000; settle();
        chk("t2_ack1", 32'(irq_ack_o), 32'h2);
        chk("t2_cause1", irq_cause_o, 32'h8000_0011);
        tick(); mret_i = 1; settle();
        chk("t2_pend3", 32'(pending_o), 32'h8);
        chk("t2_irq_busy", 32'(irq_o), 32'd0);
        chk("t2_ret", 32'(irq_ret_o), 32'd1);
        tick(); mret_i = 0; settle();
        chk("t2_irq3", 32'(irq_o), 32'd1);
        chk("t2_ack3", 32'(irq_ack_o), 32'h8);
        chk("t2_cause3", irq_cause_o, 32'h8000_0013);
        chk("t2_pend3_kept", 32'(pending_o), 32'h8);
        irq_req_i = 4'b0000; tick(); settle();
        chk("t2_pend3_gone", 32'(pending_o), 32'd0);
        mret_i = 1; tick(); mret_i = 0;

        // stall blocks taking for 3 cycles
        stall_i = 1; irq_req_i = 4'b0001; tick(); irq_req_i = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            settle(); chk("t3_stall_irq", 32'(irq_o), 32'd0); tick();
        end
        stall_i = 0; settle();
        chk("t3_unstall_irq", 32'(irq_o), 32'd1);
        chk("t3_cause", irq_cause_o, 32'h8000_0010);
        tick(); mret_i = 1; tick(); mret_i = 0;

        // exception in the unstall cycle pre-empts the IRQ
        stall_i = 1; irq_req_i = 4'b0001; tick(); irq_req_i = 4'b0000; settle();
        chk("t3b_stall_irq", 32'(irq_o), 32'd0);
        tick(); stall_i = 0; exception_i = 1; settle();
        chk("t3b_exc_irq", 32'(irq_o), 32'd0);
        chk("t3b_exc_ack", 32'(irq_ack_o), 32'd0);
        tick(); exception_i = 0; mret_i = 1; settle();
        chk("t3b_exc_ret", 32'(irq_ret_o), 32'd0);
        chk("t3b_exc_noirq", 32'(irq_o), 32'd0);
        tick(); mret_i = 0; settle();
        chk("t3b_irq", 32'(irq_o), 32'd1);
        chk("t3b_ack", 32'(irq_ack_o), 32'h1);
        tick();

        // exception inside handler, then two mrets
        exception_i = 1; mret_i = 1; settle();
        chk("t4_exc_wins", 32'(irq_ret_o), 32'd0);
        tick(); exception_i = 0; mret_i = 1; settle();
        chk("t4_irqexc_ret", 32'(irq_ret_o), 32'd0);
        chk("t4_irqexc_cause", irq_cause_o, 32'h8000_0010);
        chk("t4_irqexc_irq", 32'(irq_o), 32'd0);
        tick(); settle();
        chk("t4_ret", 32'(irq_ret_o), 32'd1);
        chk("t4_cause", irq_cause_o, 32'h8000_0010);
        tick(); mret_i = 0;

        // global mask holds pending on level source 2
        mie_global_i = 0; irq_req_i = 4'b0100; tick(); settle();
        chk("t5_masked_irq", 32'(irq_o), 32'd0);
        chk("t5_masked_pend", 32'(pending_o), 32'h4);
        tick(); settle();
        chk("t5_masked_pend2", 32'(pending_o), 32'h4);
        mie_global_i = 1; settle();
        chk("t5_irq", 32'(irq_o), 32'd1);
        chk("t5_cause", irq_cause_o, 32'h8000_0012);
        chk("t5_ack", 32'(irq_ack_o), 32'h4);
        tick(); settle();
        chk("t5_level_kept", 32'(pending_o), 32'h4);
        irq_req_i = 4'b0000; mret_i = 1; tick(); mret_i = 0;

        // new edge on source 1 in its ack cycle keeps it pending
        mie_global_i = 0; irq_req_i = 4'b0010; tick(); irq_req_i = 4'b0000; tick(); settle();
        chk("t5b_pend", 32'(pending_o), 32'h2);
        chk("t5b_masked", 32'(irq_o), 32'd0);
        mie_global_i = 1; irq_req_i = 4'b0010; settle();
        chk("t5b_ack", 32'(irq_ack_o), 32'h2);
        tick(); irq_req_i = 4'b0000; settle();
        chk("t5b_edge_kept", 32'(pending_o), 32'h2);

        // asynchronous reset mid-handler, between edges
        #1; rst_ni = 0; mret_i = 1; #1;
        chk("t6_irq", 32'(irq_o), 32'd0);
        chk("t6_ack", 32'(irq_ack_o), 32'd0);
        chk("t6_ret", 32'(irq_ret_o), 32'd0);
        chk("t6_cause", irq_cause_o, 32'd0);
        chk("t6_pend", 32'(pending_o), 32'd0);
        mret_i = 0; tick(); tick(); rst_ni = 1; settle();
        chk("t6_post_irq", 32'(irq_o), 32'd0);
        chk("t6_post_cause", irq_cause_o, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick(); settle();
            chk("t6_not_serviced", 32'(irq_o), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
